uart_tx_fifo_cts: RTL and testbench

//  Buffered 8N1 serial transmitter with hardware flow control, the sending end of the
//  RTS/CTS link driven by our receivers. A 2^FIFO_AW-entry FIFO decouples CPU writes from

---
 rtl/uart_tx_fifo_cts.sv | 125 ++++++++++++
 tb/tb_uart_tx_fifo_cts.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_cts.sv
// uart_tx_fifo_cts: buffered 8N1 serial transmitter with a small FIFO and RTS/CTS flow control.
// A frame starts only when the synchronized cts permits it; frames in progress always complete.
module uart_tx_fifo_cts #(
    parameter int CLK     = 24000000,
    parameter int BPS     = 115200,
    parameter int PERIOD  = CLK / BPS,
    parameter int FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] txdata,
    input  logic       txbegin,
    output logic       txfull,
    output logic       txempty,
    output logic       txbusy,
    output logic       txovf,
    input  logic       cts,
    output logic       tx
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [15:0] LAST = 16'(PERIOD - 1);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_BIT   = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]         r_cts_sync;
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW:0]   r_wptr;
    logic [FIFO_AW:0]   r_rptr;
    logic [1:0]         r_state;
    logic [15:0]        r_cnt;
    logic [2:0]         r_bitcnt;
    logic [7:0]         r_shift;
    logic               r_tx;
    logic               r_ovf;
    logic               w_cts_s;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_tick;
    logic               w_pop;
    logic               w_tx;

    assign w_cts_s = r_cts_sync[1];
    assign w_empty = r_wptr == r_rptr;
    assign w_full  = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                     (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
    assign w_push  = txbegin && !w_full;
    assign w_tick  = r_cnt == 16'd0;
    // cts is only consulted at frame boundaries, so a mid-frame hold-off never truncates
    assign w_pop   = !w_empty && !w_cts_s && (r_state == S_IDLE || (r_state == S_STOP && w_tick));
    assign w_tx    = r_state == S_START ? 1'b0 : r_state == S_BIT ? r_shift[0] : 1'b1;

    assign txfull  = w_full;
    assign txempty = w_empty;
    assign txbusy  = r_state != S_IDLE || !w_empty;
    assign txovf   = r_ovf;
    assign tx      = r_tx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cts_sync <= 2'b11;
        else
            r_cts_sync <= {r_cts_sync[0], cts};
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr[FIFO_AW-1:0]] <= txdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_wptr <= w_push ? r_wptr + 1'b1 : r_wptr;
            r_rptr <= w_pop ? r_rptr + 1'b1 : r_rptr;
            r_ovf  <= txbegin && w_full;
        end
    end

    // tx is registered from the current state, so the line lags the FSM by one clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= LAST;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'd0;
            r_tx     <= 1'b1;
        end else begin
            r_tx  <= w_tx;
            r_cnt <= (r_state == S_IDLE || w_tick) ? LAST : r_cnt - 16'd1;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift <= r_mem[r_rptr[FIFO_AW-1:0]];
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_bitcnt <= 3'd7;
                        r_state  <= S_BIT;
                    end
                end
                S_BIT: begin
                    if (w_tick) begin
                        r_shift  <= r_shift >> 1;
                        r_bitcnt <= r_bitcnt - 3'd1;
                        r_state  <= r_bitcnt == 3'd0 ? S_STOP : S_BIT;
                    end
                end
                default: begin
                    if (w_tick) begin
                        r_shift <= w_pop ? r_mem[r_rptr[FIFO_AW-1:0]] : r_shift;
                        r_state <= w_pop ? S_START : S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo_cts.sv
// tb_uart_tx_fifo_cts: directed bench for uart_tx_fifo_cts at PERIOD=16 (frame = 160 clocks).
// A line decoder samples mid-bit; a small receiver model drives cts for the loopback case.
module tb_uart_tx_fifo_cts;
    localparam int P = 16;
    localparam int F = 10 * P;
    localparam int D = 300;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] txdata = 8'd0;
    logic       txbegin = 1'b0;
    logic       cts = 1'b1;
    logic       txfull;
    logic       txempty;
    logic       txbusy;
    logic       txovf;
    logic       tx;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         ovf_cnt = 0;

    uart_tx_fifo_cts #(.CLK(1600000), .BPS(100000), .FIFO_AW(2)) dut (
        .clk(clk), .rst(rst), .txdata(txdata), .txbegin(txbegin), .txfull(txfull),
        .txempty(txempty), .txbusy(txbusy), .txovf(txovf), .cts(cts), .tx(tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (txovf) ovf_cnt <= ovf_cnt + 1;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        txdata  = b;
        txbegin = 1'b1;
        @(negedge clk);
        txbegin = 1'b0;
    endtask

    task automatic wait_fall(input int lim);
        int n = 0;
        while (tx !== 1'b0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (tx !== 1'b0) check("fall_timeout", tx, 0);
    endtask

    task automatic get_frame(input int lim, output logic [7:0] b, output int t_fall);
        b = 8'd0;
        t_fall = -1;
        wait_fall(lim);
        if (tx !== 1'b0) return;
        t_fall = cyc;
        repeat (P / 2) @(negedge clk);
        check("start_bit", tx, 0);
        for (int i = 0; i < 8; i++) begin
            repeat (P) @(negedge clk);
            b[i] = tx;
        end
        repeat (P) @(negedge clk);
        check("stop_bit", tx, 1);
    endtask

    task automatic count_not_idle(input int n, output int hits);
        hits = 0;
        repeat (n) begin
            @(negedge clk);
            if (tx !== 1'b1) hits++;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (txbusy && n < 4 * F) begin
            @(negedge clk);
            n++;
        end
        check("drain_busy", txbusy, 0);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] got;
        int t0, tf, n, hits, ovf0, maxq;
        logic [7:0] d2 [5];
        int t2 [5];
        logic [7:0] expq [$];
        logic [7:0] rxq [$];

        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_empty", txempty, 1);
        check("rst_full", txfull, 0);
        check("rst_busy", txbusy, 0);
        check("rst_ovf", txovf, 0);
        rst = 1'b0;
        cts = 1'b0;
        repeat (4) @(negedge clk);

        // single byte: latency, bit pattern, busy release
        push(8'h55);
        t0 = cyc;
        check("t1_empty", txempty, 0);
        check("t1_busy", txbusy, 1);
        get_frame(10, b, tf);
        check("t1_data", b, 8'h55);
        check("t1_latency", tf - t0, 2);
        n = 0;
        while (txbusy && n < 2 * F) begin
            @(negedge clk);
            n++;
        end
        check("t1_busy_fall", cyc - t0, F + 1);

        // burst of six: one popped, four buffered, sixth dropped
        ovf0 = ovf_cnt;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    if (i == 4) check("t2_not_full", txfull, 0);
                    if (i == 5) check("t2_full", txfull, 1);
                    txdata  = 8'(i + 1);
                    txbegin = 1'b1;
                end
                @(negedge clk);
                txbegin = 1'b0;
                check("t2_ovf", txovf, 1);
                @(negedge clk);
                check("t2_ovf_pulse", txovf, 0);
            end
            for (int k = 0; k < 5; k++) get_frame(2 * F, d2[k], t2[k]);
        join
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t2_data%0d", k), d2[k], 8'(k + 1));
            if (k > 0) check($sformatf("t2_gap%0d", k), t2[k] - t2[k-1], F);
        end
        drain();
        check("t2_empty", txempty, 1);
        check("t2_ovf_count", ovf_cnt - ovf0, 1);

        // held by cts, released later
        cts = 1'b1;
        repeat (4) @(negedge clk);
        push(8'hA5);
        count_not_idle(3 * P, hits);
        check("t3_hold", hits, 0);
        check("t3_empty", txempty, 0);
        check("t3_busy", txbusy, 1);
        @(negedge clk);
        cts = 1'b0;
        t0 = cyc;
        get_frame(20, b, tf);
        check("t3_data", b, 8'hA5);
        check("t3_resume", 32'(tf - t0 <= 4 && tf > 0), 1);
        drain();

        // cts rises mid-frame: current frame completes, next is held
        push(8'h11);
        push(8'h22);
        fork
            get_frame(20, b, tf);
            begin
                wait_fall(20);
                repeat (5 * P + P / 2) @(negedge clk);
                cts = 1'b1;
            end
        join
        check("t4_first", b, 8'h11);
        count_not_idle(3 * P, hits);
        check("t4_hold", hits, 0);
        check("t4_pending", txempty, 0);
        cts = 1'b0;
        get_frame(20, b, tf);
        check("t4_second", b, 8'h22);
        drain();

        // async reset mid-frame discards the frame and the queued byte
        push(8'h3C);
        push(8'h77);
        wait_fall(20);
        repeat (4 * P + P / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_tx", tx, 1);
        check("t5_empty", txempty, 1);
        check("t5_busy", txbusy, 0);
        check("t5_full", txfull, 0);
        @(negedge clk);
        rst = 1'b0;
        count_not_idle(3 * F, hits);
        check("t5_no_frame", hits, 0);
        check("t5_idle_busy", txbusy, 0);

        // loopback into a slow receiver that drives cts from its buffer level
        ovf0 = ovf_cnt;
        maxq = 0;
        cts  = 1'b0;
        fork
            for (int i = 0; i < 16; i++) begin
                logic [7:0] v;
                int w;
                v = 8'($urandom_range(0, 255));
                expq.push_back(v);
                w = 0;
                while (txfull && w < 10 * D) begin
                    @(negedge clk);
                    w++;
                end
                push(v);
            end
            for (int i = 0; i < 16; i++) begin
                logic [7:0] v;
                int tv;
                get_frame(4 * D + 4 * F, v, tv);
                rxq.push_back(v);
                if (rxq.size() > maxq) maxq = rxq.size();
                cts = rxq.size() >= 2;
            end
            for (int i = 0; i < 16; i++) begin
                int w;
                w = 0;
                while (rxq.size() == 0 && w < 4 * D + 4 * F) begin
                    @(negedge clk);
                    w++;
                end
                repeat (D) @(negedge clk);
                if (rxq.size() > 0) begin
                    got = rxq.pop_front();
                    cts = rxq.size() >= 2;
                    check($sformatf("t6_byte%0d", i), got, expq.pop_front());
                end else begin
                    check($sformatf("t6_missing%0d", i), rxq.size(), 1);
                end
            end
        join
        check("t6_no_ovf", ovf_cnt - ovf0, 0);
        check("t6_rts_honored", 32'(maxq <= 2), 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
